// File: rtl/conv_weight_bank_if.sv
// Bus bundle between the weight buffer, the PE array and conv_weight_bank.
// The master drives beats, load/swap commands and tap_sel; the slave returns status and read data.
interface conv_weight_bank_if #(
  parameter int WEIGHT_DATA_WIDTH = 256,
  parameter int KERNEL_GROUPS     = 8
);
  logic [WEIGHT_DATA_WIDTH-1:0]               weight_bias_input_data;
  logic [KERNEL_GROUPS:0]                     weight_bias_input_valid;
  logic                                       load_start;
  logic [1:0]                                 load_mode;
  logic                                       load_done;
  logic                                       swap;
  logic                                       swap_ack;
  logic [3:0]                                 tap_sel;
  logic [KERNEL_GROUPS*WEIGHT_DATA_WIDTH-1:0] weight_tap_out;
  logic [WEIGHT_DATA_WIDTH-1:0]               bias_out;
  logic                                       active_w;
  logic                                       active_b;
  logic                                       err_protocol;

  modport master (
    output weight_bias_input_data, weight_bias_input_valid, load_start, load_mode, swap, tap_sel,
    input  load_done, swap_ack, weight_tap_out, bias_out, active_w, active_b, err_protocol
  );

  modport slave (
    input  weight_bias_input_data, weight_bias_input_valid, load_start, load_mode, swap, tap_sel,
    output load_done, swap_ack, weight_tap_out, bias_out, active_w, active_b, err_protocol
  );
endinterface

// File: rtl/conv_weight_bank.sv
// Double-buffered weight/bias bank: tagged beats fill the shadow bank while the PE array reads
// the active bank; a swap promotes the shadow without stalling convolution.
module conv_weight_bank #(
  parameter int WEIGHT_WIDTH  = 8,
  parameter int PE_CORE_NUM   = 32,
  parameter int KERNEL_GROUPS = 8,
  parameter int TAPS          = 9
) (
  input  logic              system_clk,
  input  logic              rst,
  conv_weight_bank_if.slave bus
);
  localparam int DW = WEIGHT_WIDTH * PE_CORE_NUM;
  localparam int GW = $clog2(KERNEL_GROUPS);
  localparam int TW = $clog2(TAPS);
  localparam int VW = KERNEL_GROUPS + 1;
  localparam logic [GW-1:0] GRP_LAST = GW'(KERNEL_GROUPS - 1);
  localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);

  // state | meaning
  // IDLE  | no load in progress; waits for load_start with a non-zero mode
  // LOAD  | streaming tagged beats into the shadow weight and/or bias bank
  // READY | shadow load complete (load_done=1); waits for swap
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t        state_q, state_n;
  logic [1:0]    mode_q, mode_n;
  logic [TW-1:0] tap_q, tap_n;
  logic [GW-1:0] grp_q, grp_n;
  logic          bias_q, bias_n;
  logic          aw_q, aw_n, ab_q, ab_n;
  logic          ack_q, ack_n;
  logic          err_q, err_n;

  logic [VW-1:0] exp_tag;
  logic          beat_any, beat_ok;

  logic [DW-1:0] w_mem [2][KERNEL_GROUPS][TAPS];
  logic [DW-1:0] b_mem [2];

  logic [KERNEL_GROUPS*DW-1:0] rd_w_q, rd_w_n;
  logic [DW-1:0]               rd_b_q;

  assign exp_tag  = bias_q ? (VW'(1) << KERNEL_GROUPS) : (VW'(1) << grp_q);
  assign beat_any = |bus.weight_bias_input_valid;
  // Equality with a one-hot tag also rejects any non-one-hot valid pattern.
  assign beat_ok  = (state_q == LOAD) && (bus.weight_bias_input_valid == exp_tag);

  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    tap_n   = tap_q;
    grp_n   = grp_q;
    bias_n  = bias_q;
    aw_n    = aw_q;
    ab_n    = ab_q;
    ack_n   = 1'b0;
    err_n   = err_q | (beat_any && !beat_ok) | (bus.swap && state_q != READY);
    case (state_q)
      LOAD: begin
        if (beat_ok) begin
          if (bias_q) begin
            state_n = READY;
          end else if (tap_q == TAP_LAST) begin
            tap_n = '0;
            if (grp_q == GRP_LAST) begin
              if (mode_q[1]) bias_n = 1'b1;
              else           state_n = READY;
            end else begin
              grp_n = grp_q + 1'b1;
            end
          end else begin
            tap_n = tap_q + 1'b1;
          end
        end
      end
      READY: begin
        if (bus.swap) begin
          aw_n    = aw_q ^ mode_q[0];
          ab_n    = ab_q ^ mode_q[1];
          ack_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: ;
    endcase
    // A new load_start wins over the phase decision above; a swap in the same cycle still applies.
    if (bus.load_start) begin
      if (bus.load_mode != 2'b00) begin
        state_n = LOAD;
        mode_n  = bus.load_mode;
        tap_n   = '0;
        grp_n   = '0;
        bias_n  = !bus.load_mode[0];
      end else if (state_q != IDLE) begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      tap_q   <= '0;
      grp_q   <= '0;
      bias_q  <= 1'b0;
      aw_q    <= 1'b0;
      ab_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      tap_q   <= tap_n;
      grp_q   <= grp_n;
      bias_q  <= bias_n;
      aw_q    <= aw_n;
      ab_q    <= ab_n;
      ack_q   <= ack_n;
      err_q   <= err_n;
    end
  end

  always_ff @(posedge system_clk) begin
    if (beat_ok) begin
      if (bias_q) b_mem[~ab_q] <= bus.weight_bias_input_data;
      else        w_mem[~aw_q][grp_q][tap_q] <= bus.weight_bias_input_data;
    end
  end

  // Reads follow the next-cycle pointers so a swap is visible on the very next cycle.
  always_comb begin
    rd_w_n = '0;
    if (bus.tap_sel < TW'(TAPS)) begin
      for (int k = 0; k < KERNEL_GROUPS; k++) begin
        rd_w_n[k*DW +: DW] = w_mem[aw_n][GW'(k)][bus.tap_sel];
      end
    end
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      rd_w_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_w_q <= rd_w_n;
      rd_b_q <= b_mem[ab_n];
    end
  end

  assign bus.load_done      = (state_q == READY);
  assign bus.swap_ack       = ack_q;
  assign bus.weight_tap_out = rd_w_q;
  assign bus.bias_out       = rd_b_q;
  assign bus.active_w       = aw_q;
  assign bus.active_b       = ab_q;
  assign bus.err_protocol   = err_q;
endmodule
